// File: rtl/execute_stage.sv
// execute_stage: ALU, branch resolution and iterative shift-add MUL behind the decoder; owns halt/stall.
// Optional macro EXEC_FORWARD_EN enables a one-deep bypass from the registered ex_wb result. Rev 1.0
`default_nettype none

module execute_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1,
  parameter bit HALT_ON_ILLEGAL    = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [175:0] id_ex,
  input  logic         id_valid,
  output logic [70:0]  ex_wb,
  output logic         ex_valid,
  output logic         stall,
  output logic         halted
);

  localparam int MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;

  typedef enum logic [1:0] {RUN = 2'd0, MUL_BUSY = 2'd1, HALT = 2'd2} state_t;
  state_t state;

  logic [31:0] instr, pc, rs_in, rt_in, imm, rs_val, rt_val;
  logic [15:0] op;
  logic [4:0]  rs_fld, rt_fld, rd_fld;

  assign instr  = id_ex[31:0];
  assign pc     = id_ex[63:32];
  assign rs_in  = id_ex[95:64];
  assign rt_in  = id_ex[127:96];
  assign imm    = id_ex[159:128];
  assign op     = id_ex[175:160];
  assign rs_fld = instr[25:21];
  assign rt_fld = instr[20:16];
  assign rd_fld = instr[15:11];

`ifdef EXEC_FORWARD_EN
  logic fwd_ok;
  assign fwd_ok = ex_wb[37] && (ex_wb[36:32] != 5'd0);
  assign rs_val = (fwd_ok && ex_wb[36:32] == rs_fld) ? ex_wb[31:0] : rs_in;
  assign rt_val = (fwd_ok && ex_wb[36:32] == rt_fld) ? ex_wb[31:0] : rt_in;
`else
  assign rs_val = rs_in;
  assign rt_val = rt_in;
`endif

  logic unused_bits;
  assign unused_bits = ^{instr[31:26], instr[10:0], rs_fld, rt_fld};

  logic legal, is_hlt, is_mul;
  assign legal  = (op != 16'd0) && ((op & (op - 16'd1)) == 16'd0);
  assign is_hlt = legal ? op[13] : HALT_ON_ILLEGAL;
  assign is_mul = legal && op[12];

  // Single-cycle result; MUL/HLT/NOP/illegal fall through to the all-zero default.
  logic [31:0] res, target;
  logic [4:0]  dest;
  logic        we, taken;

  always_comb begin
    res    = 32'd0;
    target = 32'd0;
    dest   = 5'd0;
    we     = 1'b0;
    taken  = 1'b0;
    case (op)
      16'h0001: begin res = rs_val + rt_val;           dest = rd_fld; we = 1'b1; end
      16'h0002: begin res = rs_val - rt_val;           dest = rd_fld; we = 1'b1; end
      16'h0004: begin res = imm;                       dest = rt_fld; we = 1'b1; end
      16'h0008: begin res = rs_val << rt_val[4:0];     dest = rd_fld; we = 1'b1; end
      16'h0010: begin res = rs_val >> rt_val[4:0];     dest = rd_fld; we = 1'b1; end
      16'h0020: begin res = rs_val & rt_val;           dest = rd_fld; we = 1'b1; end
      16'h0040: begin res = rs_val | rt_val;           dest = rd_fld; we = 1'b1; end
      16'h0080: begin res = rs_val ^ rt_val;           dest = rd_fld; we = 1'b1; end
      16'h0100: begin target = pc + (imm << 2); taken = 1'b1; end
      16'h0200: begin target = pc + (imm << 2); taken = (rs_val != rt_val); end
      16'h0400: begin res = rs_val;                    dest = rt_fld; we = 1'b1; end
      16'h0800: begin res = rs_val + imm;              dest = rt_fld; we = 1'b1; end
      default: ;
    endcase
  end

  logic [31:0] mul_a, mul_b, mul_acc, acc_next;
  logic [4:0]  mul_dest;
  logic [5:0]  mul_cnt;

  // Only the low 32 product bits are kept, so the shifted multiplicand may truncate freely.
  always_comb begin
    acc_next = mul_acc;
    for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (mul_b[i]) acc_next = acc_next + (mul_a << i);
    end
  end

  assign stall = (state == MUL_BUSY);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      ex_wb    <= 71'd0;
      ex_valid <= 1'b0;
      halted   <= 1'b0;
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      mul_acc  <= 32'd0;
      mul_dest <= 5'd0;
      mul_cnt  <= 6'd0;
    end else begin
      ex_valid <= 1'b0;
      case (state)
        RUN: begin
          if (id_valid) begin
            if (is_hlt) begin
              state    <= HALT;
              halted   <= 1'b1;
              ex_wb    <= 71'd0;
              ex_valid <= 1'b1;
            end else if (is_mul) begin
              state    <= MUL_BUSY;
              mul_a    <= rs_val;
              mul_b    <= rt_val;
              mul_acc  <= 32'd0;
              mul_dest <= rd_fld;
              mul_cnt  <= 6'd0;
            end else begin
              ex_wb    <= {taken, target, we, dest, res};
              ex_valid <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          mul_acc <= acc_next;
          mul_a   <= mul_a << MUL_BITS_PER_CYCLE;
          mul_b   <= mul_b >> MUL_BITS_PER_CYCLE;
          mul_cnt <= mul_cnt + 6'd1;
          if (mul_cnt == 6'(MUL_STEPS - 1)) begin
            ex_wb    <= {1'b0, 32'd0, 1'b1, mul_dest, acc_next};
            ex_valid <= 1'b1;
            state    <= RUN;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized stimulus against an arithmetic reference model, plus directed literal checks.
`default_nettype none

module tb_execute_stage;
  localparam int BPC = 1;
  localparam bit HOI = 1'b0;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [175:0] id_ex = '0;
  logic         id_valid = 1'b0;
  logic [70:0]  ex_wb;
  logic         ex_valid, stall, halted;

  execute_stage #(.MUL_BITS_PER_CYCLE(BPC), .HALT_ON_ILLEGAL(HOI)) dut (
    .clock(clock), .reset_n(reset_n), .id_ex(id_ex), .id_valid(id_valid),
    .ex_wb(ex_wb), .ex_valid(ex_valid), .stall(stall), .halted(halted)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] wb(input logic tk, input logic [31:0] tg, input logic w,
                                     input logic [4:0] d, input logic [31:0] r);
    return {tk, tg, w, d, r};
  endfunction

  // Reference model: behaviour from the op table, MUL as a plain product with a busy countdown.
  logic [70:0] m_wb = '0;
  logic        m_valid = 1'b0, m_halted = 1'b0;
  int          m_busy = 0;
  logic [31:0] m_mres = '0;
  logic [4:0]  m_mdest = '0;

  always @(posedge clock or negedge reset_n) begin : mdl
    logic [31:0] ins, pc, rs, rt, imm, tgt;
    logic [15:0] op;
    if (!reset_n) begin
      m_wb = '0; m_valid = 1'b0; m_halted = 1'b0; m_busy = 0;
    end else begin
      m_valid = 1'b0;
      if (m_halted) begin
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_wb = wb(1'b0, 32'd0, 1'b1, m_mdest, m_mres);
          m_valid = 1'b1;
        end
      end else if (id_valid) begin
        ins = id_ex[31:0]; pc = id_ex[63:32]; rs = id_ex[95:64]; rt = id_ex[127:96];
        imm = id_ex[159:128]; op = id_ex[175:160];
`ifdef EXEC_FORWARD_EN
        if (m_wb[37] && m_wb[36:32] != 0 && m_wb[36:32] == ins[25:21]) rs = m_wb[31:0];
        if (m_wb[37] && m_wb[36:32] != 0 && m_wb[36:32] == ins[20:16]) rt = m_wb[31:0];
`endif
        if ($countones(op) != 1) op = HOI ? 16'h2000 : 16'h4000;
        tgt = pc + imm * 32'd4;
        m_valid = 1'b1;
        case (op)
          16'h0001: m_wb = wb(0, 0, 1, ins[15:11], rs + rt);
          16'h0002: m_wb = wb(0, 0, 1, ins[15:11], rs - rt);
          16'h0004: m_wb = wb(0, 0, 1, ins[20:16], imm);
          16'h0008: m_wb = wb(0, 0, 1, ins[15:11], rs << (rt % 32));
          16'h0010: m_wb = wb(0, 0, 1, ins[15:11], rs >> (rt % 32));
          16'h0020: m_wb = wb(0, 0, 1, ins[15:11], rs & rt);
          16'h0040: m_wb = wb(0, 0, 1, ins[15:11], rs | rt);
          16'h0080: m_wb = wb(0, 0, 1, ins[15:11], rs ^ rt);
          16'h0100: m_wb = wb(1, tgt, 0, 0, 0);
          16'h0200: m_wb = wb(rs != rt, tgt, 0, 0, 0);
          16'h0400: m_wb = wb(0, 0, 1, ins[20:16], rs);
          16'h0800: m_wb = wb(0, 0, 1, ins[20:16], rs + imm);
          16'h1000: begin
            m_mres = rs * rt; m_mdest = ins[15:11]; m_busy = 32 / BPC; m_valid = 1'b0;
          end
          16'h2000: begin m_halted = 1'b1; m_wb = '0; end
          default:  m_wb = '0;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    check("ex_wb", ex_wb, m_wb);
    check("ex_valid", {70'd0, ex_valid}, {70'd0, m_valid});
    check("stall", {70'd0, stall}, {70'd0, m_busy > 0});
    check("halted", {70'd0, halted}, {70'd0, m_halted});
  end

  // Present an instruction; hold it while stalled; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [15:0] op, input logic [31:0] ins, pc, rs, rt, imm);
    int n;
    id_ex = {op, imm, rt, rs, pc, ins};
    id_valid = 1'b1;
    n = 0;
    while (stall && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) check("issue timeout", 71'd1, 71'd0);
    @(posedge clock); #1;
    id_valid = 1'b0;
  endtask

  task automatic mul_test(input logic [31:0] rs, rt, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    logic early;
    issue(16'h1000, {16'd0, rd, 11'd0}, 32'd0, rs, rt, 32'd0);
    id_ex = {16'h0001, 32'd0, 32'd1, 32'd1, 32'd0, 16'd0, 5'd5, 11'd0};
    id_valid = 1'b1;
    n = 0; early = 1'b0;
    while (stall && n < 100) begin
      @(posedge clock); #1; n++;
      if (stall && ex_valid) early = 1'b1;
    end
    check("mul busy cycles", 71'(n), 71'(32 / BPC));
    check("mul early valid", {70'd0, early}, 71'd0);
    check("mul result", ex_wb, wb(0, 0, 1, rd, exp));
    check("mul valid", {70'd0, ex_valid}, 71'd1);
    @(posedge clock); #1;
    id_valid = 1'b0;
    check("held add result", ex_wb, wb(0, 0, 1, 5'd5, 32'd2));
    check("held add valid", {70'd0, ex_valid}, 71'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] op;
    #20;
    check("reset ex_wb", ex_wb, 71'd0);
    check("reset flags", {68'd0, ex_valid, stall, halted}, 71'd0);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;

    issue(16'h0001, 32'(15 << 11), 32'd0, 32'd5, 32'd3, 32'd0);
    check("add 5+3", ex_wb, wb(0, 0, 1, 5'd15, 32'd8));
    check("add valid", {70'd0, ex_valid}, 71'd1);
    issue(16'h0010, 32'(3 << 11), 32'd0, 32'h8000_0000, 32'h21, 32'd0);
    check("srl", ex_wb, wb(0, 0, 1, 5'd3, 32'h4000_0000));
    issue(16'h0002, 32'(4 << 11), 32'd0, 32'd0, 32'd1, 32'd0);
    check("sub 0-1", ex_wb, wb(0, 0, 1, 5'd4, 32'hFFFF_FFFF));
    issue(16'h0200, 32'd0, 32'h40, 32'd2, 32'd2, 32'hFFFF_FFFF);
    check("bne equal", ex_wb, wb(0, 32'h3C, 0, 0, 0));
    issue(16'h0200, 32'd0, 32'h40, 32'd2, 32'd3, 32'hFFFF_FFFF);
    check("bne differ", ex_wb, wb(1, 32'h3C, 0, 0, 0));

    mul_test(32'd7, 32'd6, 5'd9, 32'd42);
    mul_test(32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFE);

    issue(16'h0004, 32'(17 << 16), 32'd0, 32'd0, 32'd0, 32'd9);
    check("li r17", ex_wb, wb(0, 0, 1, 5'd17, 32'd9));
    issue(16'h0001, 32'((17 << 21) | (6 << 11)), 32'd0, 32'd1, 32'd1, 32'd0);
`ifdef EXEC_FORWARD_EN
    check("forward add", ex_wb, wb(0, 0, 1, 5'd6, 32'd10));
`else
    check("no-forward add", ex_wb, wb(0, 0, 1, 5'd6, 32'd2));
`endif
    issue(16'h0004, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9);
    issue(16'h0001, 32'(6 << 11), 32'd0, 32'd1, 32'd1, 32'd0);
    check("r0 never forwards", ex_wb, wb(0, 0, 1, 5'd6, 32'd2));

    // Reset mid-MUL
    issue(16'h1000, 32'(7 << 11), 32'd0, 32'd3, 32'd3, 32'd0);
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("reset mid-mul", {ex_wb, ex_valid, stall, halted}, 74'd0);
    #1 reset_n = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      check("no stray valid", {70'd0, ex_valid}, 71'd0);
    end

    issue(16'h2000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("hlt pulse", {ex_wb, ex_valid, halted}, {71'd0, 1'b1, 1'b1});
    issue(16'h0001, 32'(2 << 11), 32'd0, 32'd1, 32'd1, 32'd0);
    check("add while halted", {ex_wb, ex_valid, halted}, {71'd0, 1'b0, 1'b1});
    #1 reset_n = 1'b0;
    #1 check("reset mid-halt", {ex_wb, ex_valid, stall, halted}, 74'd0);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] rs, rt;
      r = $urandom_range(0, 99);
      if (r < 3) op = 16'd0;
      else if (r < 6) op = (16'd1 << $urandom_range(0, 14)) | (16'd1 << $urandom_range(0, 14));
      else if (r < 7) op = 16'h2000;
      else begin
        op = 16'd1 << $urandom_range(0, 14);
        if (op == 16'h2000) op = 16'h4000;
      end
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      id_ex = {op, 32'($urandom), rt, rs, 32'($urandom),
               6'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 11'd0};
      id_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0 || (halted && $urandom_range(0, 19) == 0)) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      @(posedge clock); #1;
    end
    id_valid = 1'b0;
    @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage directly downstream of the instruction decoder.
- Consumes the 176-bit ID_EX bundle and computes ALU results, branch decisions and iterative multiplies.
- Produces the 71-bit EX_WB bundle that returns to the decoder's register-file write port.
- Owns the pipeline halt state and the stall back-pressure for multi-cycle MUL.

Parameters:
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per busy cycle; legal values 1, 2, 4; MUL busy time = 32/MUL_BITS_PER_CYCLE cycles.
- HALT_ON_ILLEGAL, 0, when 1 a zero or multi-hot opcode field enters HALT; when 0 it is treated as NOP.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_ex  in  176  [31:0] instr, [63:32] PC, [95:64] rs value, [127:96] rt value, [159:128] sign-extended imm, [175:160] one-hot op (bit0 ADD, 1 SUB, 2 LI, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 XOR, 8 BR, 9 BNE, 10 MOV, 11 ADI, 12 MUL, 13 HLT, 14 NOP).
- id_valid  in  1  id_ex holds a new instruction this cycle.
- ex_wb  out  71  [31:0] result, [36:32] dest reg, [37] write enable, [69:38] branch target, [70] branch taken.
- ex_valid  out  1  one-cycle pulse when ex_wb is updated.
- stall  out  1  high while MUL busy; upstream holds id_ex and id_valid.
- halted  out  1  sticky after HLT.

Behaviour:
- Reset (async, reset_n=0): ex_wb=0, ex_valid=0, stall=0, halted=0, FSM=RUN, MUL counter and accumulator cleared. Reset during a MUL abandons it; no ex_valid is produced.
- Instruction is accepted when id_valid=1, FSM=RUN and the HALT state is not active. In all other states, id_valid is ignored.
- Single-cycle ops: result registered on the accepting edge; ex_valid=1 for exactly that following cycle.
- Destination register:
  - instr[15:11] for ADD/SUB/SLL/SRL/AND/OR/XOR/MUL.
  - instr[20:16] for LI/ADI/MOV.
- Op results (32-bit wrap, no overflow flags):
  - ADD: rs+rt; SUB: rs-rt.
  - SLL: rs<<rt[4:0]; SRL: rs>>rt[4:0] (logical).
  - AND/OR/XOR: bitwise rs with rt.
  - LI: imm; MOV: rs; ADI: rs+imm.
- Write enable: we=1 for the ops above; we=0 for BR, BNE, NOP, HLT.
- Branches:
  - target = PC + (imm<<2), mod 2^32.
  - BR: taken=1.
  - BNE: taken = (rs != rt).
  - Result and dest are 0 for branches.
  - Non-branch ops drive taken=0 and target=0.
- NOP: ex_valid=1, all ex_wb fields 0.
- Illegal one-hot (zero or more than one bit set):
  - HALT_ON_ILLEGAL=0: behaves as NOP.
  - HALT_ON_ILLEGAL=1: behaves as HLT.
- FSM states: RUN, MUL_BUSY, HALT.
  - RUN: accepted MUL latches rs, rt and dest, clears the counter, then goes to MUL_BUSY. Accepted HLT goes to HALT.
  - MUL_BUSY: stall=1 (combinational from state). Shift-add retires MUL_BITS_PER_CYCLE multiplier bits per cycle. On the edge where the counter reaches 32/MUL_BITS_PER_CYCLE, write the low 32 bits of the product (we=1), pulse ex_valid and return to RUN.
  - Next acceptance is possible on the first RUN cycle after MUL_BUSY.
  - HALT: halted=1, stall=0, ex_valid=0, ex_wb holds its last value. Only reset exits HALT.
- HLT: ex_valid pulses once with all-zero ex_wb on entry to HALT.
- Operand fields of id_ex are sampled only on the acceptance edge.

Optional Feature:
- Macro EXEC_FORWARD_EN.
- Defined: one-deep bypass.
  - If the previous ex_valid pulse had we=1, dest≠0 and dest == instr[25:21], the rs operand is replaced by the registered ex_wb result.
  - The same rule applies to rt using instr[20:16].
  - Applies to every op, including MUL operand latching and BNE compare.
- Undefined: operands are taken from id_ex unmodified.

Test Plan:
- Reset, then ADD with rs=5, rt=3, instr[15:11]=15, id_valid=1 -> next cycle ex_valid=1, result=8, dest=15, we=1, taken=0.
- SRL rs=0x80000000, rt=0x21 -> result=0x40000000 (shift amount 1); SUB 0-1 -> 0xFFFFFFFF.
- BNE rs=2, rt=2, PC=0x40, imm=0xFFFFFFFF -> taken=0, target=0x3C; repeat with rt=3 -> taken=1, target=0x3C, we=0.
- MUL rs=7, rt=6, MUL_BITS_PER_CYCLE=1 -> stall high 32 cycles; a second ADD held on id_valid is ignored until stall drops; result=42, dest correct; ADD then executes. Repeat with rs=0xFFFFFFFF, rt=2 -> 0xFFFFFFFE.
- HLT -> one ex_valid with zero ex_wb, halted=1; later ADDs produce no ex_valid; assert reset_n mid-MUL and mid-HALT -> all outputs 0, FSM=RUN, no stray ex_valid.
- With EXEC_FORWARD_EN: LI imm=9 to r17, then ADD rs field=17 carrying stale rs=1, rt=1 -> result=10; with the macro undefined -> result=2; dest=0 producer never forwards.
